btb_update_ctrl: RTL and testbench

//  Sequences all writes into the 4-entry BTB and turns branch resolution into

---
 rtl/btb_update_ctrl_pkg.sv | 30 +++
 rtl/btb_update_fifo.sv | 95 +++++++++
 rtl/btb_update_ctrl.sv | 146 ++++++++++++++
 tb/tb_btb_update_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/btb_update_ctrl_pkg.sv
// Shared types for the BTB update controller.
//   lc3b_word        : 16-bit machine word
//   btb_upd_t        : one pending BTB write {pc, target}
//   BTB_SENTINEL     : PC/target written by the init sweep (odd, never fetched)
//   btb_ctrl_state_t : controller state {INIT, RUN}
package btb_update_ctrl_pkg;

  typedef logic [15:0] lc3b_word;

  typedef struct packed {
    lc3b_word pc;
    lc3b_word target;
  } btb_upd_t;

  localparam lc3b_word BTB_SENTINEL = 16'hFFFF;

  typedef enum logic [0:0] {
    INIT,
    RUN
  } btb_ctrl_state_t;

  // Fetch went the wrong way, or went the right way to the wrong place.
  function automatic logic is_mispredict(input logic     taken,
                                         input lc3b_word target,
                                         input logic     pred_taken,
                                         input lc3b_word pred_target);
    return (taken != pred_taken) | (taken & pred_taken & (target != pred_target));
  endfunction

endpackage

// File: rtl/btb_update_fifo.sv
// Circular update queue feeding the BTB write port.
//   clk, rst_n : clock, synchronous active-low reset
//   push       : enqueue request carrying push_data
//   push_data  : {pc, target} to enqueue or merge
//   pop        : dequeue the head (ignored when empty)
//   head       : current head entry, with a same-cycle merge bypassed in
//   full/empty : occupancy flags
// A push whose PC matches a queued entry overwrites that entry's target and
// takes no new slot. A push into a full queue is accepted only alongside a pop.
module btb_update_fifo
  import btb_update_ctrl_pkg::*;
#(
  parameter int unsigned QDEPTH = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  btb_upd_t push_data,
  input  logic     pop,
  output btb_upd_t head,
  output logic     full,
  output logic     empty
);

  localparam int unsigned PtrW = $clog2(QDEPTH);

  btb_upd_t         mem_q [QDEPTH];
  logic [PtrW-1:0]  rd_q, wr_q;
  logic [PtrW:0]    cnt_q;

  logic [QDEPTH-1:0] slot_valid;
  logic [QDEPTH-1:0] hit;
  logic              merge;
  logic              do_pop;
  logic              do_push;

  assign full  = (cnt_q == (PtrW + 1)'(QDEPTH));
  assign empty = (cnt_q == '0);

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    slot_valid = '0;
    hit        = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      logic [PtrW-1:0] off;
      off           = PtrW'(i) - rd_q;
      slot_valid[i] = ({1'b0, off} < cnt_q);
      hit[i]        = slot_valid[i] & (mem_q[i].pc == push_data.pc);
    end
  end

  assign merge   = push & (|hit);
  assign do_pop  = pop & !empty;
  assign do_push = push & !merge & (!full | do_pop);

  // Merging into the head while it is popped must still write the new target.
  always_comb begin
    head = mem_q[rd_q];
    if (push && hit[rd_q]) begin
      head.target = push_data.target;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (merge) begin
        for (int i = 0; i < QDEPTH; i++) begin
          if (hit[i]) begin
            mem_q[i].target <= push_data.target;
          end
        end
      end
      if (do_push) begin
        mem_q[wr_q] <= push_data;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_q <= rd_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB write sequencer and mispredict redirect generator.
//   clk, rst_n        : clock, synchronous active-low reset
//   res_*             : branch resolution from MEM (valid, pc, taken, target)
//   pred_taken/target : what fetch used for this branch
//   btb_wr_inhibit    : fetch needs a stable BTB; suppress any write this cycle
//   btb_load/br_pc/target : BTB write port (combinational, same-cycle write)
//   redirect/redirect_pc/flush : registered 1-cycle redirect to fetch
//   ready             : init sweep complete
//   mispredict_cnt    : saturating redirect count
// After reset the BTB is swept with a sentinel PC so no stale entry can hit;
// afterwards queued updates drain one per cycle when not inhibited.
module btb_update_ctrl
  import btb_update_ctrl_pkg::*;
#(
  parameter int unsigned ENTRIES = 4,
  parameter int unsigned QDEPTH  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        res_valid,
  input  logic [15:0] res_pc,
  input  logic        res_taken,
  input  logic [15:0] res_target,
  input  logic        pred_taken,
  input  logic [15:0] pred_target,
  input  logic        btb_wr_inhibit,
  output logic        btb_load,
  output logic [15:0] btb_br_pc,
  output logic [15:0] btb_target,
  output logic        redirect,
  output logic [15:0] redirect_pc,
  output logic        flush,
  output logic        ready,
  output logic [15:0] mispredict_cnt
);

  localparam int unsigned IdxW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(ENTRIES - 1);

  btb_ctrl_state_t state_q;
  logic [IdxW-1:0] idx_q;
  logic            ready_q;
  logic            redirect_q;
  lc3b_word        redirect_pc_q;
  lc3b_word        cnt_q;

  logic     wr_ok;
  logic     mispredict;
  logic     enqueue;
  logic     q_pop;
  logic     q_full;
  logic     q_empty;
  btb_upd_t q_head;
  btb_upd_t q_in;

  // Writes are also held off while reset is asserted so every output reads 0.
  assign wr_ok = rst_n & !btb_wr_inhibit;

  assign mispredict = res_valid & is_mispredict(res_taken, res_target, pred_taken, pred_target);
  // Only taken branches that fetch did not steer correctly need a BTB entry.
  assign enqueue    = res_valid & res_taken & (!pred_taken | (res_target != pred_target));
  assign q_in       = '{pc: res_pc, target: res_target};
  assign q_pop      = (state_q == RUN) & wr_ok & !q_empty;

  btb_update_fifo #(
    .QDEPTH (QDEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (enqueue),
    .push_data (q_in),
    .pop       (q_pop),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty)
  );

  always_comb begin
    btb_load   = 1'b0;
    btb_br_pc  = '0;
    btb_target = '0;
    unique case (state_q)
      INIT: begin
        if (wr_ok) begin
          btb_load   = 1'b1;
          btb_br_pc  = BTB_SENTINEL;
          btb_target = BTB_SENTINEL;
        end
      end
      RUN: begin
        if (q_pop) begin
          btb_load   = 1'b1;
          btb_br_pc  = q_head.pc;
          btb_target = q_head.target;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= INIT;
      idx_q         <= '0;
      ready_q       <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      cnt_q         <= '0;
    end else begin
      unique case (state_q)
        INIT: begin
          if (!btb_wr_inhibit) begin
            if (idx_q == LastIdx) begin
              state_q <= RUN;
              ready_q <= 1'b1;
              idx_q   <= '0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        RUN: begin
          state_q <= RUN;
        end
      endcase

      redirect_q <= mispredict;
      if (mispredict) begin
        redirect_pc_q <= res_taken ? res_target : (res_pc + 16'd2);
        if (cnt_q != 16'hFFFF) begin
          cnt_q <= cnt_q + 16'd1;
        end
      end
    end
  end

  assign ready          = ready_q;
  assign redirect       = redirect_q;
  assign flush          = redirect_q;
  assign redirect_pc    = redirect_pc_q;
  assign mispredict_cnt = cnt_q;

  // Overflow is intentional: a full queue drops the push.
  logic unused_full;
  assign unused_full = q_full;

endmodule

// File: tb/tb_btb_update_ctrl.sv
module tb_btb_update_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        res_valid;
  logic [15:0] res_pc;
  logic        res_taken;
  logic [15:0] res_target;
  logic        pred_taken;
  logic [15:0] pred_target;
  logic        btb_wr_inhibit;
  logic        btb_load;
  logic [15:0] btb_br_pc;
  logic [15:0] btb_target;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        flush;
  logic        ready;
  logic [15:0] mispredict_cnt;

  int checks = 0;
  int errors = 0;

  btb_update_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .res_valid      (res_valid),
    .res_pc         (res_pc),
    .res_taken      (res_taken),
    .res_target     (res_target),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .btb_wr_inhibit (btb_wr_inhibit),
    .btb_load       (btb_load),
    .btb_br_pc      (btb_br_pc),
    .btb_target     (btb_target),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .ready          (ready),
    .mispredict_cnt (mispredict_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resolve(input logic [15:0] pc, input logic tk, input logic [15:0] tgt,
                         input logic ptk, input logic [15:0] ptgt);
    res_valid   = 1'b1;
    res_pc      = pc;
    res_taken   = tk;
    res_target  = tgt;
    pred_taken  = ptk;
    pred_target = ptgt;
  endtask

  task automatic idle_res();
    res_valid = 1'b0;
  endtask

  // Expect exactly ENTRIES sentinel writes, then ready with no write.
  task automatic sweep_check(input string tag);
    for (int i = 0; i < 4; i++) begin
      #1;
      check({tag, "_load"}, {31'd0, btb_load}, 32'd1);
      check({tag, "_pc"}, {16'd0, btb_br_pc}, 32'h0000_FFFF);
      check({tag, "_tgt"}, {16'd0, btb_target}, 32'h0000_FFFF);
      check({tag, "_notready"}, {31'd0, ready}, 32'd0);
      tick();
    end
    #1;
    check({tag, "_ready"}, {31'd0, ready}, 32'd1);
    check({tag, "_idle"}, {31'd0, btb_load}, 32'd0);
  endtask

  initial begin
    rst_n          = 1'b0;
    res_valid      = 1'b0;
    res_pc         = '0;
    res_taken      = 1'b0;
    res_target     = '0;
    pred_taken     = 1'b0;
    pred_target    = '0;
    btb_wr_inhibit = 1'b0;
    tick();
    tick();
    #1;
    check("rst_load", {31'd0, btb_load}, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_redirect", {31'd0, redirect}, 32'd0);
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_rpc", {16'd0, redirect_pc}, 32'd0);
    check("rst_cnt", {16'd0, mispredict_cnt}, 32'd0);
    tick();

    // 1: init sweep
    rst_n = 1'b1;
    sweep_check("sweep1");

    // 2: taken mispredict -> redirect + BTB write next cycle
    tick();
    resolve(16'h3000, 1'b1, 16'h3040, 1'b0, 16'h0000);
    tick();
    idle_res();
    #1;
    check("t2_redirect", {31'd0, redirect}, 32'd1);
    check("t2_flush", {31'd0, flush}, 32'd1);
    check("t2_rpc", {16'd0, redirect_pc}, 32'h3040);
    check("t2_cnt", {16'd0, mispredict_cnt}, 32'd1);
    check("t2_load", {31'd0, btb_load}, 32'd1);
    check("t2_wpc", {16'd0, btb_br_pc}, 32'h3000);
    check("t2_wtgt", {16'd0, btb_target}, 32'h3040);
    tick();
    #1;
    check("t2_redirect_off", {31'd0, redirect}, 32'd0);
    check("t2_load_off", {31'd0, btb_load}, 32'd0);

    // 3: not-taken mispredicts, fall-through and wrap
    tick();
    resolve(16'h3010, 1'b0, 16'h1234, 1'b1, 16'h1234);
    tick();
    idle_res();
    #1;
    check("t3_redirect", {31'd0, redirect}, 32'd1);
    check("t3_rpc", {16'd0, redirect_pc}, 32'h3012);
    check("t3_noenq", {31'd0, btb_load}, 32'd0);
    check("t3_cnt", {16'd0, mispredict_cnt}, 32'd2);
    tick();
    resolve(16'hFFFE, 1'b0, 16'h1234, 1'b1, 16'h1234);
    tick();
    idle_res();
    #1;
    check("t3_wrap_rpc", {16'd0, redirect_pc}, 32'h0000);
    check("t3_wrap_redirect", {31'd0, redirect}, 32'd1);
    check("t3_wrap_cnt", {16'd0, mispredict_cnt}, 32'd3);
    tick();
    #1;
    check("t3_wrap_noenq", {31'd0, btb_load}, 32'd0);

    // 4: full queue drops the third push
    btb_wr_inhibit = 1'b1;
    resolve(16'h0010, 1'b1, 16'h0110, 1'b0, 16'h0000);
    tick();
    resolve(16'h0020, 1'b1, 16'h0120, 1'b0, 16'h0000);
    tick();
    resolve(16'h0030, 1'b1, 16'h0130, 1'b0, 16'h0000);
    #1;
    check("t4_inhibited", {31'd0, btb_load}, 32'd0);
    tick();
    idle_res();
    #1;
    check("t4_rpc", {16'd0, redirect_pc}, 32'h0130);
    check("t4_cnt", {16'd0, mispredict_cnt}, 32'd6);
    btb_wr_inhibit = 1'b0;
    #1;
    check("t4_w1_load", {31'd0, btb_load}, 32'd1);
    check("t4_w1", {btb_br_pc, btb_target}, 32'h0010_0110);
    tick();
    #1;
    check("t4_w2_load", {31'd0, btb_load}, 32'd1);
    check("t4_w2", {btb_br_pc, btb_target}, 32'h0020_0120);
    tick();
    #1;
    check("t4_dropped", {31'd0, btb_load}, 32'd0);

    // 5: merge of same PC while inhibited
    btb_wr_inhibit = 1'b1;
    resolve(16'h0010, 1'b1, 16'h0050, 1'b0, 16'h0000);
    tick();
    resolve(16'h0010, 1'b1, 16'h0060, 1'b0, 16'h0000);
    tick();
    idle_res();
    btb_wr_inhibit = 1'b0;
    #1;
    check("t5_load", {31'd0, btb_load}, 32'd1);
    check("t5_merged", {btb_br_pc, btb_target}, 32'h0010_0060);
    tick();
    #1;
    check("t5_one_entry", {31'd0, btb_load}, 32'd0);
    check("t5_cnt", {16'd0, mispredict_cnt}, 32'd8);

    // Merge into the head while it is being popped
    resolve(16'h0040, 1'b1, 16'h0070, 1'b0, 16'h0000);
    tick();
    resolve(16'h0040, 1'b1, 16'h0080, 1'b0, 16'h0000);
    #1;
    check("mpop_load", {31'd0, btb_load}, 32'd1);
    check("mpop_write", {btb_br_pc, btb_target}, 32'h0040_0080);
    tick();
    idle_res();
    #1;
    check("mpop_empty", {31'd0, btb_load}, 32'd0);
    check("mpop_cnt", {16'd0, mispredict_cnt}, 32'd10);

    // 6a: reset with a full queue
    btb_wr_inhibit = 1'b1;
    resolve(16'h0100, 1'b1, 16'h0A00, 1'b0, 16'h0000);
    tick();
    resolve(16'h0200, 1'b1, 16'h0B00, 1'b0, 16'h0000);
    tick();
    idle_res();
    rst_n = 1'b0;
    tick();
    #1;
    check("t6a_ready", {31'd0, ready}, 32'd0);
    check("t6a_cnt", {16'd0, mispredict_cnt}, 32'd0);
    check("t6a_redirect", {31'd0, redirect}, 32'd0);
    check("t6a_load", {31'd0, btb_load}, 32'd0);
    tick();
    rst_n          = 1'b1;
    btb_wr_inhibit = 1'b0;
    sweep_check("sweep2");

    // 6b: reset during sweep cycle 2
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("t6b_first", {31'd0, btb_load}, 32'd1);
    tick();
    rst_n = 1'b0;
    #1;
    check("t6b_rst_load", {31'd0, btb_load}, 32'd0);
    tick();
    rst_n = 1'b1;
    sweep_check("sweep3");

    // Correct prediction: no redirect, no write
    resolve(16'h0500, 1'b1, 16'h0600, 1'b1, 16'h0600);
    tick();
    idle_res();
    #1;
    check("ok_redirect", {31'd0, redirect}, 32'd0);
    check("ok_load", {31'd0, btb_load}, 32'd0);
    check("ok_cnt", {16'd0, mispredict_cnt}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
